// File: rtl/arc4_enc.sv
// ARC4 encryptor: length-prefixed plaintext RAM -> length-prefixed ciphertext RAM.
// Optional macro ARC4_ENC_DROP_EN discards DROP_N keystream bytes after key scheduling.
module arc4_enc #(
  parameter int KEY_BYTES = 3,
  parameter int DROP_N    = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             pt_addr,
  input  logic [7:0]             pt_rddata,
  output logic [7:0]             ct_addr,
  output logic [7:0]             ct_wrdata,
  output logic                   ct_wren
);

  // state      | meaning
  // IDLE       | rdy=1, waiting for en
  // INIT       | S[i]=i, one entry per cycle
  // KSA        | key schedule, one swap per cycle
  // DROP       | discarded PRGA steps (ARC4_ENC_DROP_EN only)
  // LEN_WAIT   | pt[0] read in flight
  // LEN        | capture L, write ct[0]
  // PRGA_REQ   | present pt[k] address
  // PRGA_WAIT  | pt[k] read in flight
  // PRGA_STEP  | one PRGA step, write ct[k]
  // DONE       | raise rdy
  typedef enum logic [3:0] {
    ST_IDLE, ST_INIT, ST_KSA, ST_DROP, ST_LEN_WAIT, ST_LEN,
    ST_PRGA_REQ, ST_PRGA_WAIT, ST_PRGA_STEP, ST_DONE
  } state_t;

  localparam int KW = 8*KEY_BYTES;
`ifdef ARC4_ENC_DROP_EN
  localparam int DROP_STEPS = DROP_N;
`else
  localparam int DROP_STEPS = DROP_N * 0;  // plain ARC4: drop phase never entered
`endif

  state_t          r_state;
  logic [7:0]      r_s [256];
  logic [7:0]      r_i, r_j, r_k, r_len;
  logic [KW-1:0]   r_key;
  logic [15:0]     r_drop_cnt;
  logic            r_rdy, r_ct_wren;
  logic [7:0]      r_pt_addr, r_ct_addr, r_ct_wrdata;

  logic [7:0] w_kbyte;
  logic [7:0] w_ksa_si, w_ksa_j, w_ksa_sj;
  logic [7:0] w_pi, w_psi, w_pj, w_psj, w_t, w_pad;
  logic       w_is_ksa, w_swap;
  logic [7:0] w_sa, w_sb, w_va, w_vb;

  assign w_kbyte  = r_key[KW-1 -: 8];
  assign w_ksa_si = r_s[r_i];
  assign w_ksa_j  = r_j + w_ksa_si + w_kbyte;
  assign w_ksa_sj = r_s[w_ksa_j];

  assign w_pi  = r_i + 8'd1;
  assign w_psi = r_s[w_pi];
  assign w_pj  = r_j + w_psi;
  assign w_psj = r_s[w_pj];
  assign w_t   = w_psi + w_psj;
  // pad is read from the post-swap array, so redirect hits on the two swapped slots
  assign w_pad = (w_t == w_pi) ? w_psj :
                 (w_t == w_pj) ? w_psi : r_s[w_t];

  assign w_is_ksa = (r_state == ST_KSA);
  assign w_swap   = w_is_ksa || (r_state == ST_DROP) || (r_state == ST_PRGA_STEP);
  assign w_sa     = w_is_ksa ? r_i      : w_pi;
  assign w_sb     = w_is_ksa ? w_ksa_j  : w_pj;
  assign w_va     = w_is_ksa ? w_ksa_si : w_psi;
  assign w_vb     = w_is_ksa ? w_ksa_sj : w_psj;

  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_s[r_i] <= r_i;
    end else if (w_swap) begin
      r_s[w_sa] <= w_vb;
      r_s[w_sb] <= w_va;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rdy       <= 1'b1;
      r_ct_wren   <= 1'b0;
      r_pt_addr   <= 8'd0;
      r_ct_addr   <= 8'd0;
      r_ct_wrdata <= 8'd0;
      r_i         <= 8'd0;
      r_j         <= 8'd0;
      r_k         <= 8'd0;
      r_len       <= 8'd0;
      r_key       <= '0;
      r_drop_cnt  <= 16'd0;
    end else begin
      r_ct_wren <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en && r_rdy) begin
            r_key   <= key;
            r_rdy   <= 1'b0;
            r_i     <= 8'd0;
            r_state <= ST_INIT;
          end
        end
        ST_INIT: begin
          r_i <= r_i + 8'd1;
          if (r_i == 8'hFF) begin
            r_j     <= 8'd0;
            r_state <= ST_KSA;
          end
        end
        ST_KSA: begin
          r_i   <= r_i + 8'd1;
          r_j   <= w_ksa_j;
          r_key <= (r_key << 8) | (r_key >> (KW-8));
          if (r_i == 8'hFF) begin
            r_i        <= 8'd0;
            r_j        <= 8'd0;
            r_pt_addr  <= 8'd0;
            r_drop_cnt <= 16'd0;
            r_state    <= (DROP_STEPS > 0) ? ST_DROP : ST_LEN_WAIT;
          end
        end
        ST_DROP: begin
          r_i        <= w_pi;
          r_j        <= w_pj;
          r_drop_cnt <= r_drop_cnt + 16'd1;
          if (r_drop_cnt == 16'(DROP_STEPS-1)) r_state <= ST_LEN_WAIT;
        end
        ST_LEN_WAIT: r_state <= ST_LEN;
        ST_LEN: begin
          r_len       <= pt_rddata;
          r_ct_wren   <= 1'b1;
          r_ct_addr   <= 8'd0;
          r_ct_wrdata <= pt_rddata;
          r_k         <= 8'd1;
          r_state     <= (pt_rddata == 8'd0) ? ST_DONE : ST_PRGA_REQ;
        end
        ST_PRGA_REQ: begin
          r_pt_addr <= r_k;
          r_state   <= ST_PRGA_WAIT;
        end
        ST_PRGA_WAIT: r_state <= ST_PRGA_STEP;
        ST_PRGA_STEP: begin
          r_i         <= w_pi;
          r_j         <= w_pj;
          r_ct_wren   <= 1'b1;
          r_ct_addr   <= r_k;
          r_ct_wrdata <= pt_rddata ^ w_pad;
          if (r_k == r_len) begin
            r_state <= ST_DONE;
          end else begin
            r_k     <= r_k + 8'd1;
            r_state <= ST_PRGA_REQ;
          end
        end
        ST_DONE: begin
          r_rdy   <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rdy       = r_rdy;
  assign pt_addr   = r_pt_addr;
  assign ct_addr   = r_ct_addr;
  assign ct_wrdata = r_ct_wrdata;
  assign ct_wren   = r_ct_wren;

endmodule

// File: doc/arc4_enc.md
Name: arc4_enc

Overview:
- ARC4 encryptor: the write-direction counterpart of the arc4 decrypt core.
- Reads a length-prefixed plaintext message from an external plaintext RAM and writes the length-prefixed ciphertext to an external ciphertext RAM.
- Holds the 256-byte S state internally.
- Uses the same en/rdy start handshake as the decrypt core, so the two can be chained for round-trip checks and drop into the same top level.

Parameters:
- KEY_BYTES, 3: key length in bytes; key port width is 8*KEY_BYTES.
- DROP_N, 256: keystream bytes discarded before encryption; used only with ARC4_ENC_DROP_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  start pulse; sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- key  in  8*KEY_BYTES  key; byte 0 = key[8*KEY_BYTES-1 -: 8] (MSB first).
- pt_addr  out  8  plaintext RAM read address.
- pt_rddata  in  8  plaintext RAM read data; synchronous RAM, valid 1 cycle after pt_addr.
- ct_addr  out  8  ciphertext RAM write address.
- ct_wrdata  out  8  ciphertext write data.
- ct_wren  out  1  ciphertext write strobe; one write per cycle when high.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, rdy=1, ct_wren=0.
  - pt_addr, ct_addr, ct_wrdata = 0.
  - S contents undefined.
- Handshake:
  - en with rdy=1 at a rising edge: key is latched and rdy drops the next cycle.
  - en while rdy=0 is ignored.
  - Changes to key after acceptance have no effect.
- State INIT: S[i]=i for i=0..255. Any cycle count is allowed.
- State KSA, for i=0..255, 8-bit wrap arithmetic:
  - j = j + S[i] + keybyte[i mod KEY_BYTES].
  - swap S[i], S[j]; j starts at 0.
- State LEN:
  - read pt[0] to get L (0..255).
  - write ct[0]=L.
- State PRGA, for k=1..L, with i,j reset to 0 at PRGA entry:
  - i=i+1; j=j+S[i]; swap S[i], S[j].
  - pad = S[(S[i]+S[j]) mod 256].
  - ct[k] = pt[k] ^ pad.
- Address rules:
  - Every ct write uses ct_addr = message index k.
  - Each address is written exactly once per run; no writes beyond index L.
- L=0: only ct[0]=0 is written, then DONE.
- State DONE: rdy=1 the following cycle, then IDLE. A new en may be accepted on the first cycle rdy=1.
- Latency: rdy returns at most 2048 + 8*L cycles after en acceptance (at most 4088 for L=255).
- Reset mid-operation: immediate return to IDLE and ct_wren=0. Partial ciphertext left in RAM is not cleared.
- S storage: implementation choice, either a register array or an internal single-port RAM; the latency bound applies either way.

Optional Feature:
- Macro: ARC4_ENC_DROP_EN.
- Defined:
  - After KSA, run DROP_N PRGA steps before LEN, with no RAM accesses during them.
  - i,j carry over from the drop phase into PRGA; they are not reset.
  - Latency bound grows by 4*DROP_N.
- Undefined: DROP_N is ignored; plain ARC4.

Test Plan:
- KEY_BYTES=3, key=24'h4B6579 ("Key"), pt = {9,"Plaintext"} -> ct = {09,BB,F3,16,E8,D9,40,AF,0A,D3}; rdy high within 2120 cycles.
- KEY_BYTES=4, key=32'h57696B69 ("Wiki"), pt = {5,"pedia"} -> ct = {05,10,21,BF,04,20}.
- key=24'h000155, pt[0]=0 -> exactly one write (ct[0]=00) and rdy returns; en pulsed while busy -> no second run, write count unchanged.
- key=24'h000155, random 255-byte message -> feed the ct output into the arc4 decrypt core with the same key -> recovered pt equals the original byte-for-byte.
- Start an L=200 run, assert rst_n=0 at PRGA byte 50 -> ct_wren=0 and rdy=1 immediately; a fresh run then produces correct ciphertext.
- ARC4_ENC_DROP_EN, DROP_N=256, key=24'h4B6579, L=9 -> ct matches a software RC4-drop256 model and differs from the plain vector.
